// File: rtl/spi_slave_xfer_pkg.sv
// Shared definitions for the SPI responder.
//   spi_state_e    : FSM state codes (ST_IDLE=0, ST_SHIFT=1)
//   SCLK_CLK_RATIO : minimum CLK cycles per SCLK period
//   cnt_w()        : width of a counter able to hold 0..n
package spi_slave_xfer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    localparam int SCLK_CLK_RATIO = 8;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_slave_xfer_if.sv
// Local-side port bundle of the SPI responder.
//   tx_data/tx_valid/tx_ready : valid/ready load of the next word to send
//   rx_data/rx_valid          : last received word and its 1-CLK strobe
//   tx_underrun/xfer_abort    : 1-CLK status strobes
// Modports: slave = responder side, master = local logic side.
interface spi_slave_xfer_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              xfer_abort;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, xfer_abort
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, xfer_abort
    );
endinterface

// File: rtl/spi_slave_xfer_sync.sv
// spi_sync_ff: STAGES-deep flop synchronizer for an asynchronous pin.
//   CLK, CLR : system clock, asynchronous active-high reset
//   rst_val  : value every stage takes during reset (tie to a constant)
//   d        : asynchronous input
//   q        : synchronized output
module spi_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic CLR,
    input  logic rst_val,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) ff <= {STAGES{rst_val}};
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_slave_xfer.sv
// spi_slave_xfer: SPI mode-0 responder running on the system clock.
// SCLK/CS_N/MOSI are oversampled; SCLK must be at most CLK/8.
//   CLK, CLR      : system clock, asynchronous active-high reset
//   SCLK,CS_N,MOSI: SPI pins from the master (asynchronous)
//   MISO, MISO_OE : serial data to the master and its output enable
//   bus           : local TX load / RX strobe port (spi_slave_xfer_if.slave)
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift LSB first on both
// lines; the default is MSB first.
module spi_slave_xfer
    import spi_slave_xfer_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SYNC_STG = 2
) (
    input  logic CLK,
    input  logic CLR,
    input  logic SCLK,
    input  logic CS_N,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_OE,
    spi_slave_xfer_if.slave bus
);
    localparam int CW = cnt_w(DATA_W);

    // ---------------- pin synchronizers + edge detect ----------------
    logic sclk_s, csn_s, mosi_s;
    logic sclk_d, csn_d;

    spi_sync_ff #(.STAGES(SYNC_STG)) u_sync_sclk (
        .CLK(CLK), .CLR(CLR), .rst_val(1'b0), .d(SCLK), .q(sclk_s));
    spi_sync_ff #(.STAGES(SYNC_STG)) u_sync_csn (
        .CLK(CLK), .CLR(CLR), .rst_val(1'b1), .d(CS_N), .q(csn_s));
    spi_sync_ff #(.STAGES(SYNC_STG)) u_sync_mosi (
        .CLK(CLK), .CLR(CLR), .rst_val(1'b0), .d(MOSI), .q(mosi_s));

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sclk_d <= 1'b0;
            csn_d  <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            csn_d  <= csn_s;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign cs_fall   = ~csn_s  &  csn_d;
    assign cs_rise   =  csn_s  & ~csn_d;

    // ---------------- FSM ----------------
    spi_state_e state_q, state_d;
    logic cs_start, cs_stop, sh_rise, sh_fall;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // SCLK edges only count in SHIFT, and a CS_N rise masks a coincident edge.
    always_comb begin
        state_d  = state_q;
        cs_start = 1'b0;
        cs_stop  = 1'b0;
        sh_rise  = 1'b0;
        sh_fall  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d  = ST_SHIFT;
                    cs_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    cs_stop = 1'b1;
                end else begin
                    sh_rise = sclk_rise;
                    sh_fall = sclk_fall;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [DATA_W-1:0] buf_data, tx_shreg, rx_data_q, rx_word;
    logic [DATA_W-2:0] rx_shreg;
    logic [CW-1:0]     bit_cnt;
    logic buf_full, word_end, miso_oe_q;
    logic rx_valid_q, underrun_q, abort_q;
    logic drain, load_acc, tx_bit;

    // A new TX word is needed at frame start and on the fall that follows a
    // completed word.
    assign drain    = cs_start | (sh_fall & word_end);
    // The ready seen here is the pre-drain state, so a drain and a load in
    // the same CLK resolve as drain first, then load into the empty buffer.
    assign load_acc = bus.tx_valid & ~buf_full;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_word = {mosi_s, rx_shreg};
    assign tx_bit  = tx_shreg[0];
`else
    assign rx_word = {rx_shreg, mosi_s};
    assign tx_bit  = tx_shreg[DATA_W-1];
`endif

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            buf_data   <= '0;
            buf_full   <= 1'b0;
            tx_shreg   <= '0;
            rx_shreg   <= '0;
            rx_data_q  <= '0;
            bit_cnt    <= '0;
            word_end   <= 1'b0;
            miso_oe_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;

            // TX holding buffer
            if (drain)    buf_full <= 1'b0;
            if (load_acc) begin
                buf_full <= 1'b1;
                buf_data <= bus.tx_data;
            end

            // TX shift register
            if (drain) begin
                tx_shreg   <= buf_full ? buf_data : '0;
                underrun_q <= ~buf_full;
            end else if (sh_fall) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                tx_shreg <= {1'b0, tx_shreg[DATA_W-1:1]};
`else
                tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
`endif
            end
            if (sh_fall) word_end <= 1'b0;

            if (cs_start) begin
                bit_cnt   <= '0;
                miso_oe_q <= 1'b1;
                word_end  <= 1'b0;
            end

            // RX sampling
            if (sh_rise) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                rx_shreg <= rx_word[DATA_W-1:1];
`else
                rx_shreg <= rx_word[DATA_W-2:0];
`endif
                if (bit_cnt == CW'(DATA_W - 1)) begin
                    rx_data_q  <= rx_word;
                    rx_valid_q <= 1'b1;
                    bit_cnt    <= '0;
                    word_end   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end

            // End of frame: any partial word and the loaded TX word are dropped.
            if (cs_stop) begin
                abort_q   <= (bit_cnt != '0);
                bit_cnt   <= '0;
                miso_oe_q <= 1'b0;
                word_end  <= 1'b0;
                tx_shreg  <= '0;
                rx_shreg  <= '0;
            end
        end
    end

    assign MISO            = miso_oe_q & tx_bit;
    assign MISO_OE         = miso_oe_q;
    assign bus.tx_ready    = ~buf_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.xfer_abort  = abort_q;
endmodule
